// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared definitions for the LED sequencer: FSM state encoding,
//               default timing constants and a counter-width helper.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents    : state_t            - FSM state encoding (2 bits)
//               DEF_DIV            - default clk cycles per tick
//               DEF_PERIOD         - default ticks per counter period
//               DEF_DEB_CYCLES     - default debounce length in clk cycles
//               cnt_width()        - register width needed to count 0..n-1
// ============================================================================
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int DEF_DIV        = 2400;    // 20 kHz tick from 48 MHz
  localparam int DEF_PERIOD     = 40000;
  localparam int DEF_DEB_CYCLES = 480000;  // 10 ms at 48 MHz

  // A counter running 0..n-1 needs $clog2(n) bits; keep at least one bit so
  // degenerate n=1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce
// Description : Single-bit 2-flop synchronizer followed by a debouncer. The
//               output follows the synchronized input only after the two have
//               differed for DEB_CYCLES consecutive clk cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk    in  - clock, rising edge
//               reset  in  - asynchronous, active-low reset
//               din    in  - raw level, asynchronous to clk
//               dout   out - synchronized, debounced level (registered)
// ============================================================================
module sync_debounce
  import led_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int            CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // Any agreement between input and output restarts the qualification
      // window, so only an uninterrupted run of differing cycles flips dout.
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : LED sequence controller. Debounces four DIP switches, and
//               runs a prescaled modulo-PERIOD sequence counter under an
//               IDLE/RUN/PAUSE state machine.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk      in  - clock, rising edge
//               reset    in  - asynchronous, active-low reset
//               s_raw    in  [3:0]  - raw DIP switch levels (async)
//               run      in  - level request to advance the counter
//               clear    in  - synchronous return to IDLE (beats run)
//               s_clean  out [3:0]  - synchronized, debounced switches
//               counter  out [15:0] - sequence count, 0..PERIOD-1
//               tick     out - one-cycle prescaler pulse
//               wrap     out - one-cycle pulse as counter returns to 0
//               state    out [1:0]  - FSM state encoding
// ============================================================================
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int DIV        = DEF_DIV,
  parameter int PERIOD     = DEF_PERIOD,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_raw,
  input  logic        run,
  input  logic        clear,
  output logic [3:0]  s_clean,
  output logic [15:0] counter,
  output logic        tick,
  output logic        wrap,
  output logic [1:0]  state
);

  localparam int            PW            = cnt_width(DIV);
  localparam logic [PW-1:0] PRE_LAST      = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_NEXT_LAST = PW'(DIV - 2);
  localparam logic [15:0]   CNT_LAST      = 16'(PERIOD - 1);

  state_t        fsm;
  logic [PW-1:0] pre_cnt;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_deb
      sync_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk  (clk),
        .reset(reset),
        .din  (s_raw[i]),
        .dout (s_clean[i])
      );
    end
  endgenerate

  // tick is registered, so it is computed one cycle early from the value
  // pre_cnt is about to take: it is high exactly while state is RUN and
  // pre_cnt sits at DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm     <= ST_IDLE;
      pre_cnt <= '0;
      counter <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else if (clear) begin
      // Any tick pending this cycle is dropped.
      fsm     <= ST_IDLE;
      pre_cnt <= '0;
      counter <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          pre_cnt <= '0;
          counter <= '0;
          tick    <= 1'b0;
          wrap    <= 1'b0;
          if (run) begin
            fsm <= ST_RUN;
          end
        end

        ST_RUN: begin
          // The tick is honoured even when run drops in the same cycle.
          if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            if (counter == CNT_LAST) begin
              counter <= '0;
              wrap    <= 1'b1;
            end else begin
              counter <= counter + 16'd1;
              wrap    <= 1'b0;
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
            wrap    <= 1'b0;
          end
          tick <= run && (pre_cnt == PRE_NEXT_LAST);
          if (!run) begin
            fsm <= ST_PAUSE;
          end
        end

        ST_PAUSE: begin
          // pre_cnt and counter hold; resuming may land straight on a tick.
          wrap <= 1'b0;
          tick <= run && (pre_cnt == PRE_LAST);
          if (run) begin
            fsm <= ST_RUN;
          end
        end

        default: begin
          fsm     <= ST_IDLE;
          pre_cnt <= '0;
          counter <= '0;
          tick    <= 1'b0;
          wrap    <= 1'b0;
        end
      endcase
    end
  end

  assign state = fsm;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Scoreboard bench for led_seq_ctrl with DIV=4, PERIOD=5,
//               DEB_CYCLES=3. Stimulus queues hand-computed expected output
//               vectors tagged with the clk cycle they are due; a monitor
//               samples after each rising edge (and on reset assertion) and
//               compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;
  import led_pkg::*;

  localparam int DIV = 4;
  localparam int PERIOD = 5;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s_raw;
  logic        run;
  logic        clear;
  logic [3:0]  s_clean;
  logic [15:0] counter;
  logic        tick;
  logic        wrap;
  logic [1:0]  state;

  led_seq_ctrl #(
    .DIV(DIV),
    .PERIOD(PERIOD),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_raw(s_raw),
    .run(run),
    .clear(clear),
    .s_clean(s_clean),
    .counter(counter),
    .tick(tick),
    .wrap(wrap),
    .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          at;
    bit          mid;   // sample right after a reset assertion, not a clk edge
    string       name;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        tk;
    logic        wr;
    logic [3:0]  sc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_mid;
  exp_t mon_e;

  task automatic expect_v(input int ahead, input bit mid, input string nm,
                          input logic [1:0] st, input int cnt, input logic tk,
                          input logic wr, input logic [3:0] sc);
    exp_t e;
    e.at   = cyc + ahead;
    e.mid  = mid;
    e.name = nm;
    e.st   = st;
    e.cnt  = 16'(cnt);
    e.tk   = tk;
    e.wr   = wr;
    e.sc   = sc;
    q.push_back(e);
  endtask

  // Monitor
  always @(posedge clk or negedge reset) begin
    mon_mid = (clk == 1'b0);
    #2;
    while (q.size() > 0 && (q[0].at < cyc || (q[0].at == cyc && q[0].mid == mon_mid))) begin
      mon_e = q.pop_front();
      vectors++;
      if (mon_e.at < cyc) begin
        miscompares++;
        $display("FAIL %s: sample missed, due cycle %0d, now cycle %0d", mon_e.name, mon_e.at, cyc);
      end else if (state !== mon_e.st || counter !== mon_e.cnt || tick !== mon_e.tk ||
                   wrap !== mon_e.wr || s_clean !== mon_e.sc) begin
        miscompares++;
        $display("FAIL %s @cyc %0d: got state=%0d counter=%0d tick=%b wrap=%b s_clean=%b, expected state=%0d counter=%0d tick=%b wrap=%b s_clean=%b",
                 mon_e.name, cyc, state, counter, tick, wrap, s_clean,
                 mon_e.st, mon_e.cnt, mon_e.tk, mon_e.wr, mon_e.sc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors pending", q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cb[12];
    int cc[6];

    reset = 1'b0;
    run   = 1'b1;
    clear = 1'b0;
    s_raw = 4'b0000;

    // Reset state
    expect_v(1, 1'b0, "reset_hold", ST_IDLE, 0, 1'b0, 1'b0, 4'b0000);
    expect_v(2, 1'b0, "reset_hold", ST_IDLE, 0, 1'b0, 1'b0, 4'b0000);
    repeat (2) @(negedge clk);

    // Release with run=1: RUN next cycle, tick every 4th, counter 0..4,0
    reset = 1'b1;
    for (int n = 1; n <= 30; n++)
      expect_v(n, 1'b0, "run_count", ST_RUN, ((n - 1) / 4) % 5, (n % 4) == 0, n == 21, 4'b0000);
    repeat (30) @(negedge clk);

    // Drop run at counter=2 (pre_cnt=1): pause with counter frozen
    run = 1'b0;
    for (int n = 1; n <= 10; n++)
      expect_v(n, 1'b0, "pause_hold", ST_PAUSE, 2, 1'b0, 1'b0, 4'b0000);
    repeat (10) @(negedge clk);

    // Resume: pre_cnt resumes from 2, so tick arrives on the 2nd cycle
    run = 1'b1;
    cb = '{2, 2, 3, 3, 3, 3, 4, 4, 4, 4, 0, 0};
    for (int n = 1; n <= 12; n++)
      expect_v(n, 1'b0, "resume", ST_RUN, cb[n-1], (n == 2) || (n == 6) || (n == 10), n == 11, 4'b0000);
    repeat (12) @(negedge clk);

    // Count up to a pending tick at counter=1, then clear together with run
    cc = '{0, 0, 1, 1, 1, 1};
    for (int n = 1; n <= 6; n++)
      expect_v(n, 1'b0, "pre_clear", ST_RUN, cc[n-1], (n == 2) || (n == 6), 1'b0, 4'b0000);
    repeat (6) @(negedge clk);
    clear = 1'b1;
    expect_v(1, 1'b0, "clear_vs_tick", ST_IDLE, 0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    clear = 1'b0;
    for (int n = 1; n <= 5; n++)
      expect_v(n, 1'b0, "after_clear", ST_RUN, (n == 5) ? 1 : 0, n == 4, 1'b0, 4'b0000);
    repeat (5) @(negedge clk);

    // Debounce under clear: 2-cycle glitch, 1 low, then stable high
    clear = 1'b1;
    s_raw = 4'b0001;
    for (int n = 1; n <= 10; n++)
      expect_v(n, 1'b0, "debounce", ST_IDLE, 0, 1'b0, 1'b0, (n >= 8) ? 4'b0001 : 4'b0000);
    repeat (2) @(negedge clk);
    s_raw = 4'b0000;
    @(negedge clk);
    s_raw = 4'b0001;
    repeat (7) @(negedge clk);

    // Run again, start a debounce on bit 2, then reset at counter=3
    clear = 1'b0;
    for (int n = 1; n <= 14; n++)
      expect_v(n, 1'b0, "run_pre_reset", ST_RUN, ((n - 1) / 4) % 5, (n % 4) == 0, 1'b0, 4'b0001);
    repeat (11) @(negedge clk);
    s_raw = 4'b0101;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_v(0, 1'b1, "reset_async", ST_IDLE, 0, 1'b0, 1'b0, 4'b0000);
    expect_v(1, 1'b0, "reset_mid", ST_IDLE, 0, 1'b0, 1'b0, 4'b0000);
    expect_v(2, 1'b0, "reset_mid", ST_IDLE, 0, 1'b0, 1'b0, 4'b0000);
    repeat (2) @(negedge clk);

    // Release: counting and debounce restart from zero
    reset = 1'b1;
    for (int n = 1; n <= 6; n++)
      expect_v(n, 1'b0, "post_reset", ST_RUN, (n >= 5) ? 1 : 0, n == 4, 1'b0, (n >= 5) ? 4'b0101 : 4'b0000);
    repeat (8) @(negedge clk);

    while (q.size() > 0) begin
      mon_e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never sampled, due cycle %0d, now cycle %0d", mon_e.name, mon_e.at, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 2400; clk cycles per tick (20 kHz at 48 MHz).
REQ-002 SHALL have parameter PERIOD, default 40000; ticks per counter period, 2..65536.
REQ-003 SHALL have parameter DEB_CYCLES, default 480000; clk cycles of stable input required to accept a switch change (10 ms at 48 MHz).
REQ-004 SHALL have port clk, input, 1; sole clock, all flops rising-edge.
REQ-005 SHALL have port reset, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port s_raw, input, 4; raw DIP switch levels, asynchronous to clk.
REQ-007 SHALL have port run, input, 1; level request to advance the counter.
REQ-008 SHALL have port clear, input, 1; synchronous request to return to IDLE.
REQ-009 SHALL have port s_clean, output, 4; synchronized, debounced switch levels for the LED decoder.
REQ-010 SHALL have port counter, output, 16; sequence count for the LED decoder.
REQ-011 SHALL have port tick, output, 1; one-cycle prescaler pulse.
REQ-012 SHALL have port wrap, output, 1; one-cycle pulse, counter period complete.
REQ-013 SHALL have port state, output, 2; current FSM state encoding.

Function
REQ-014 SHALL pass each s_raw bit through a 2-flop synchronizer before any other use.
REQ-015 SHALL change an s_clean bit only after its synchronized value differs from s_clean for DEB_CYCLES consecutive clk cycles; any reversion before that restarts that bit's count at 0.
REQ-016 SHALL debounce each bit independently, in every FSM state, unaffected by clear.
REQ-017 SHALL run prescaler pre_cnt 0..DIV-1 only in RUN; tick=1 for exactly the cycle pre_cnt==DIV-1 in RUN, after which pre_cnt wraps to 0.
REQ-018 SHALL have FSM states IDLE=2'd0, RUN=2'd1, PAUSE=2'd2; 2'd3 unreachable and SHALL recover to IDLE on the next cycle.
REQ-019 SHALL transition: IDLE->RUN when run=1; RUN->PAUSE when run=0; PAUSE->RUN when run=1; any state->IDLE when clear=1.
REQ-020 SHALL give clear priority over run when both are asserted in the same cycle.
REQ-021 SHALL hold counter and pre_cnt at 0 in IDLE; both SHALL freeze at their values in PAUSE and resume from them on return to RUN.
REQ-022 SHALL, on tick in RUN, set counter to 0 if counter==PERIOD-1, else counter+1 (16-bit unsigned, never exceeding PERIOD-1).
REQ-023 SHALL register wrap so it is 1 in the single cycle where counter first reads 0 after PERIOD-1.
REQ-024 SHALL still apply a tick coincident with run falling in RUN (counter advances that cycle), then enter PAUSE.
REQ-025 SHALL, on clear coincident with tick, discard the tick; next cycle counter=0, pre_cnt=0, wrap=0.
REQ-026 SHALL drive all outputs from registers; no combinational input-to-output path.

Reset
REQ-027 SHALL, while reset=0, force state=IDLE, counter=0, pre_cnt=0, tick=0, wrap=0, s_clean=4'b0000, synchronizer flops and debounce counts to 0.
REQ-028 SHALL abort any in-progress count or debounce on reset assertion mid-operation, and resume from the REQ-027 values on release.

Structure
REQ-029 SHALL place the state enum typedef and default DIV/PERIOD/DEB_CYCLES constants in shared package led_pkg.
REQ-030 SHALL implement synchronizer plus debounce as sub-module sync_debounce (1 bit, parameter DEB_CYCLES), instantiated 4 times via generate.
REQ-031 SHALL size pre_cnt and debounce counters with $clog2 of their parameters.

Verification (DIV=4, PERIOD=5, DEB_CYCLES=3)
REQ-032 SHALL test reset release with run=1: state=RUN next cycle, tick every 4th cycle, counter 0,1,2,3,4,0, wrap=1 coincident with the return to 0.
REQ-033 SHALL test s_raw[0] 0->1 glitching 2 cycles then stable: s_clean[0] rises only after 2 sync + 3 stable cycles; the glitch never propagates.
REQ-034 SHALL test run dropped at counter=2 and raised 10 cycles later: state=PAUSE, counter and pre_cnt hold, then resume 3,4,0.
REQ-035 SHALL test clear=1 and run=1 together with tick pending: next cycle state=IDLE, counter=0, wrap=0, tick=0.
REQ-036 SHALL test reset=0 asserted at counter=3 mid-debounce: all outputs zero immediately, s_clean=0.
